// File: rtl/sched_rr_arb.sv
// rtl/sched_rr_arb.sv - round-robin / fixed-priority arbiter with registered valid/ready output stage
module sched_rr_arb_lsb #(
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     vec_i,
  output logic                 vld_o,
  output logic [IDX_WIDTH-1:0] idx_o
);
  // Lowest-set-bit finder as a balanced binary tree over a power-of-two padded vector.
  localparam int LEVELS = IDX_WIDTH;
  localparam int P      = 1 << LEVELS;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [(P>>l)-1:0]    vld;
    logic [IDX_WIDTH-1:0] idx [P>>l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < P; i++) begin : g_bit
        if (i < WIDTH) begin : g_real
          assign vld[i] = vec_i[i];
        end else begin : g_pad
          assign vld[i] = 1'b0;
        end
        assign idx[i] = IDX_WIDTH'(i);
      end
    end else begin : g_node
      for (genvar n = 0; n < (P >> l); n++) begin : g_pair
        assign vld[n] = g_lvl[l-1].vld[2*n] | g_lvl[l-1].vld[2*n+1];
        assign idx[n] = g_lvl[l-1].vld[2*n] ? g_lvl[l-1].idx[2*n] : g_lvl[l-1].idx[2*n+1];
      end
    end
  end

  assign vld_o = g_lvl[LEVELS].vld[0];
  assign idx_o = g_lvl[LEVELS].idx[0];
endmodule

module sched_rr_arb #(
  parameter int       NUM_REQ    = 8,
  parameter int       DATA_WIDTH = 16,
  parameter bit       MODE       = 1'b0,
  parameter int       IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [IDX_WIDTH-1:0]          idx_o,
  output logic                          empty_o
);
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [IDX_WIDTH-1:0]  r_ptr;

  logic [NUM_REQ-1:0]    w_mask;
  logic [NUM_REQ-1:0]    w_masked;
  logic                  w_m_vld;
  logic [IDX_WIDTH-1:0]  w_m_idx;
  logic                  w_r_vld;
  logic [IDX_WIDTH-1:0]  w_r_idx;
  logic [IDX_WIDTH-1:0]  w_win_idx;
  logic [IDX_WIDTH-1:0]  w_ptr_next;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_load;
  logic                  w_grant;

  assign w_load  = (~r_valid | ready_i) & ~flush_i;
  assign w_grant = w_load & w_r_vld;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_mask
    assign w_mask[k] = (IDX_WIDTH'(k) >= r_ptr);
  end
  assign w_masked = req_i & w_mask;

  sched_rr_arb_lsb #(.WIDTH(NUM_REQ), .IDX_WIDTH(IDX_WIDTH)) u_lsb_masked (
    .vec_i (w_masked),
    .vld_o (w_m_vld),
    .idx_o (w_m_idx)
  );

  sched_rr_arb_lsb #(.WIDTH(NUM_REQ), .IDX_WIDTH(IDX_WIDTH)) u_lsb_raw (
    .vec_i (req_i),
    .vld_o (w_r_vld),
    .idx_o (w_r_idx)
  );

  // Fall back to the unmasked search once nothing at or above the pointer is asking.
  assign w_win_idx  = (MODE == 1'b0 && w_m_vld) ? w_m_idx : w_r_idx;
  assign w_ptr_next = (MODE == 1'b1 || w_win_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0
                    : w_win_idx + IDX_WIDTH'(1);

  always_comb begin
    gnt_o      = '0;
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win_idx == IDX_WIDTH'(k)) begin
        gnt_o[k]   = w_grant;
        w_win_data = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_data  <= w_win_data;
      r_idx   <= w_win_idx;
      r_ptr   <= w_ptr_next;
    end else if (w_load) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign idx_o   = r_idx;
  assign empty_o = ~|req_i;
endmodule

// File: tb/tb_sched_rr_arb.sv
// tb/tb_sched_rr_arb.sv - directed self-checking bench for sched_rr_arb
module tb_sched_rr_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-requester round-robin instance
  logic         flush, ready, valid, empty;
  logic [7:0]   req, gnt;
  logic [127:0] data;
  logic [15:0]  dout;
  logic [2:0]   idx;

  // 5-requester round-robin instance
  logic         flush5, ready5, valid5, empty5;
  logic [4:0]   req5, gnt5;
  logic [79:0]  data5;
  logic [15:0]  dout5;
  logic [2:0]   idx5;

  // 8-requester fixed-priority instance
  logic         flushf, readyf, validf, emptyf;
  logic [7:0]   reqf, gntf;
  logic [127:0] dataf;
  logic [15:0]  doutf;
  logic [2:0]   idxf;

  int n_cmp = 0;
  int n_err = 0;

  sched_rr_arb #(.NUM_REQ(8), .DATA_WIDTH(16), .MODE(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_i(req), .data_i(data),
    .gnt_o(gnt), .valid_o(valid), .ready_i(ready), .data_o(dout), .idx_o(idx), .empty_o(empty)
  );

  sched_rr_arb #(.NUM_REQ(5), .DATA_WIDTH(16), .MODE(1'b0)) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush5), .req_i(req5), .data_i(data5),
    .gnt_o(gnt5), .valid_o(valid5), .ready_i(ready5), .data_o(dout5), .idx_o(idx5), .empty_o(empty5)
  );

  sched_rr_arb #(.NUM_REQ(8), .DATA_WIDTH(16), .MODE(1'b1)) u_dut_fp (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flushf), .req_i(reqf), .data_i(dataf),
    .gnt_o(gntf), .valid_o(validf), .ready_i(readyf), .data_o(doutf), .idx_o(idxf), .empty_o(emptyf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = '0; req5 = '0; reqf = '0;
    flush = 1'b0; flush5 = 1'b0; flushf = 1'b0;
    ready = 1'b1; ready5 = 1'b1; readyf = 1'b1;
    for (int k = 0; k < 8; k++) data[k*16 +: 16] = 16'h0A00 + 16'(k);
    for (int k = 0; k < 5; k++) data5[k*16 +: 16] = 16'h0500 + 16'(k);
    for (int k = 0; k < 8; k++) dataf[k*16 +: 16] = 16'h0F00 + 16'(k);
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    req = 8'hFF;
    #1;
    n_cmp++; if (gnt !== 8'h01) begin n_err++; $display("FAIL reset_first_gnt: got %h want %h", gnt, 8'h01); end
    tick;
    n_cmp++; if (dout !== 16'h0A00) begin n_err++; $display("FAIL reset_first_data: got %h want %h", dout, 16'h0A00); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (dout !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", dout); end
    n_cmp++; if (idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", idx); end
  endtask

  task automatic test_fairness;
    logic [7:0] eg;
    logic [2:0] ei;
    do_reset;
    req = 8'hFF;
    #1;
    for (int c = 0; c < 9; c++) begin
      eg = 8'h01 << (c % 8);
      ei = 3'(c % 8);
      n_cmp++; if (gnt !== eg) begin n_err++; $display("FAIL fair_gnt[%0d]: got %h want %h", c, gnt, eg); end
      tick;
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL fair_valid[%0d]: got %b want 1", c, valid); end
      n_cmp++; if (idx !== ei) begin n_err++; $display("FAIL fair_idx[%0d]: got %0d want %0d", c, idx, ei); end
      n_cmp++; if (dout !== 16'h0A00 + 16'(ei)) begin n_err++; $display("FAIL fair_data[%0d]: got %h want %h", c, dout, 16'h0A00 + 16'(ei)); end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    req = 8'b0010_0100;
    #1;
    n_cmp++; if (gnt !== 8'h04) begin n_err++; $display("FAIL bp_first_gnt: got %h want 04", gnt); end
    tick;
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL bp_gnt[%0d]: got %h want 00", c, gnt); end
      n_cmp++; if (valid !== 1'b1 || idx !== 3'd2) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b idx=%0d want v=1 idx=2", c, valid, idx); end
      tick;
    end
    ready = 1'b1;
    #1;
    n_cmp++; if (gnt !== 8'h20) begin n_err++; $display("FAIL bp_release_gnt: got %h want 20", gnt); end
    tick;
    n_cmp++; if (idx !== 3'd5 || dout !== 16'h0A05) begin n_err++; $display("FAIL bp_next: got idx=%0d data=%h want idx=5 data=0a05", idx, dout); end
  endtask

  task automatic test_npot_wrap;
    logic [4:0] eg;
    logic [2:0] ei;
    do_reset;
    req5 = 5'b10001;
    #1;
    for (int c = 0; c < 4; c++) begin
      eg = (c % 2 == 1) ? 5'b10000 : 5'b00001;
      ei = (c % 2 == 1) ? 3'd4 : 3'd0;
      n_cmp++; if (gnt5 !== eg) begin n_err++; $display("FAIL npot_gnt[%0d]: got %b want %b", c, gnt5, eg); end
      tick;
      n_cmp++; if (idx5 !== ei || dout5 !== 16'h0500 + 16'(ei)) begin n_err++; $display("FAIL npot_out[%0d]: got idx=%0d data=%h want idx=%0d data=%h", c, idx5, dout5, ei, 16'h0500 + 16'(ei)); end
    end
  endtask

  task automatic test_fixed_prio;
    do_reset;
    reqf = 8'hFF;
    #1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (gntf !== 8'h01) begin n_err++; $display("FAIL fp_gnt[%0d]: got %h want 01", c, gntf); end
      tick;
      n_cmp++; if (validf !== 1'b1 || idxf !== 3'd0 || doutf !== 16'h0F00) begin n_err++; $display("FAIL fp_out[%0d]: got v=%b idx=%0d data=%h want v=1 idx=0 data=0f00", c, validf, idxf, doutf); end
    end
  endtask

  task automatic test_flush;
    do_reset;
    req = 8'h08;
    #1;
    n_cmp++; if (gnt !== 8'h08) begin n_err++; $display("FAIL flush_setup_gnt: got %h want 08", gnt); end
    tick;
    n_cmp++; if (valid !== 1'b1 || idx !== 3'd3) begin n_err++; $display("FAIL flush_setup_out: got v=%b idx=%0d want v=1 idx=3", valid, idx); end
    req = 8'hFF; ready = 1'b0; flush = 1'b1;
    #1;
    n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL flush_gnt: got %h want 00", gnt); end
    tick;
    flush = 1'b0;
    n_cmp++; if (valid !== 1'b0 || idx !== 3'd3) begin n_err++; $display("FAIL flush_after: got v=%b idx=%0d want v=0 idx=3", valid, idx); end
    ready = 1'b1;
    #1;
    n_cmp++; if (gnt !== 8'h01) begin n_err++; $display("FAIL flush_ptr_gnt: got %h want 01", gnt); end
    tick;
    n_cmp++; if (idx !== 3'd0 || valid !== 1'b1) begin n_err++; $display("FAIL flush_next: got v=%b idx=%0d want v=1 idx=0", valid, idx); end
  endtask

  task automatic test_drain;
    do_reset;
    req = 8'h40;
    #1;
    n_cmp++; if (gnt !== 8'h40 || empty !== 1'b0) begin n_err++; $display("FAIL drain_gnt: got gnt=%h empty=%b want gnt=40 empty=0", gnt, empty); end
    tick;
    req = 8'h00;
    #1;
    n_cmp++; if (empty !== 1'b1 || gnt !== 8'h00) begin n_err++; $display("FAIL drain_empty: got empty=%b gnt=%h want empty=1 gnt=00", empty, gnt); end
    tick;
    n_cmp++; if (valid !== 1'b0 || idx !== 3'd6 || dout !== 16'h0A06) begin n_err++; $display("FAIL drain_hold: got v=%b idx=%0d data=%h want v=0 idx=6 data=0a06", valid, idx, dout); end
    req = 8'h81;
    #1;
    n_cmp++; if (gnt !== 8'h80) begin n_err++; $display("FAIL drain_ptr_gnt: got %h want 80", gnt); end
    tick;
  endtask

  initial begin
    test_reset;
    test_fairness;
    test_backpressure;
    test_npot_wrap;
    test_fixed_prio;
    test_flush;
    test_drain;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sched_rr_arb.md
# sched_rr_arb

Parametrised round-robin arbiter with a registered valid/ready output stage. It selects one of `NUM_REQ` requesters per cycle and forwards that requester's data word and index downstream. It generalises the read scheduler's combinational leading-zero priority select. Additions over that select: a rotating priority pointer, a fixed-priority mode, backpressure, and a synchronous flush. It sits between the per-port queue request lines and the read-scheduler pipeline.

## Interface
- `NUM_REQ`, 8: number of requesters; must be ≥1; need not be a power of two.
- `DATA_WIDTH`, 16: payload width per requester.
- `MODE`, 1'b0: 0 = round-robin; 1 = fixed priority, lowest index wins.
- `IDX_WIDTH`, derived: `NUM_REQ>1 ? $clog2(NUM_REQ) : 1`. Do not override.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `flush_i` in 1: synchronous clear of output stage and pointer.
- `req_i` in NUM_REQ: request per requester. Each requester holds its request and data until granted.
- `data_i` in NUM_REQ*DATA_WIDTH: payload; requester k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `gnt_o` out NUM_REQ: one-hot grant, combinational, at most one bit set.
- `valid_o` out 1: output register holds a granted item.
- `ready_i` in 1: downstream accepts when `valid_o & ready_i`.
- `data_o` out DATA_WIDTH: registered payload of the winner.
- `idx_o` out IDX_WIDTH: registered index of the winner.
- `empty_o` out 1: combinational; `~|req_i`.

## Operation
- Load enable: `load = (~valid_o | ready_i) & ~flush_i`.
- Arbitration (combinational):
  - In round-robin mode, form `masked = req_i & {bits ≥ ptr}`.
  - If `masked` is nonzero, the winner is the lowest set index of `masked`. Otherwise it is the lowest set index of `req_i`.
  - In MODE=1, the winner is the lowest set index of `req_i`, and `ptr` is ignored and held at 0.
  - The lowest-index search is a log-depth tree.
- Grant: `gnt_o[w] = load & |req_i`; all other bits are 0.
- On a clock edge with a grant:
  - `data_o` and `idx_o` take the winner's data and index `w`.
  - `valid_o` becomes 1.
  - `ptr` becomes `(w == NUM_REQ-1) ? 0 : w+1`. Wrap is explicit and holds for non-power-of-two widths.
- On a clock edge with `load` high and no request: `valid_o` becomes 0. `data_o`, `idx_o` and `ptr` hold.
- With `valid_o & ~ready_i`: `gnt_o` is all zero, and `data_o`/`idx_o`/`valid_o` hold stable (AXI-style). `ptr` holds.
- `flush_i` takes precedence over everything: `valid_o` becomes 0 and `ptr` becomes 0 next cycle, `gnt_o` is 0 in that cycle, and any pending output item is dropped. `data_o`/`idx_o` hold.
- NUM_REQ=1: the pointer is a constant 0, `idx_o` is a constant 0, and the block degenerates to a one-entry register slice.

## Timing
- Reset values: `valid_o`=0, `data_o`=0, `idx_o`=0, `ptr`=0. `gnt_o` is then all zero whenever `req_i` is zero.
- Latency: a request in cycle t with the stage free gives `gnt_o` in cycle t and `valid_o`/`data_o` in cycle t+1.
- Throughput: one grant per cycle while `ready_i`=1. Back-to-back grants are allowed in the same cycle the current item is accepted.
- `gnt_o` and `empty_o` are combinational from `req_i`, `valid_o`, `ready_i`, `flush_i` and `ptr`. The `data_i`→`data_o` path is registered.
- Reset asserted mid-transfer clears all state immediately (asynchronously). The first grant possible is in the cycle after `rst_ni` deasserts.
- A request whose line drops before it is granted is simply not considered. No state is retained for it.

## Test plan
- Reset: assert `rst_ni`=0 with `req_i`=8'hFF → `valid_o`=0, `data_o`=0, `idx_o`=0. In the first cycle after release, `gnt_o`=8'h01.
- Full fairness: `req_i`=8'hFF, `ready_i`=1, `data_i[k]`=16'h0A00+k → `gnt_o` walks 01,02,04…80,01. `idx_o` follows 0..7,0 one cycle later, with `data_o`=16'h0A00+idx_o.
- Backpressure: `req_i`=8'b0010_0100, `ready_i`=1 for the first grant (idx 2), then 0 for 3 cycles → `valid_o`=1 and `idx_o`=2 held for 3 cycles, `gnt_o`=0. On `ready_i`=1, `gnt_o`=8'h20 and the next `idx_o`=5.
- Non-power-of-two wrap: NUM_REQ=5, `req_i`=5'b10001, `ready_i`=1 → grants alternate idx 0,4,0,4; `ptr` goes 4→0 after idx 4.
- Fixed priority: MODE=1, `req_i`=8'hFF for 4 cycles → `gnt_o`=8'h01 every cycle and `idx_o`=0.
- Flush: while `valid_o`=1, `idx_o`=3, `ready_i`=0, pulse `flush_i` → `gnt_o`=0 that cycle, `valid_o`=0 next. With `req_i`=8'hFF afterwards, the next grant is idx 0.
